// File: rtl/wvb_packed_storage.sv
`default_nettype none
// ============================================================================
// Module   : wvb_packed_storage
// Brief    : WVB storage; packs sample words into rows, tracks buffer
//            occupancy and keeps a show-ahead header FIFO.
// Revision : 1.0
// ============================================================================
module wvb_packed_storage #(
    parameter int WORD_WIDTH     = 21,
    parameter int WORDS_PER_ROW  = 4,
    parameter int ADR_WIDTH      = 10,
    parameter int HDR_WIDTH      = 104,
    parameter int HDR_DEPTH_LOG2 = 7,
    parameter int N_WVF_WIDTH    = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [WORD_WIDTH-1:0]                  word_in,
    input  logic                                   word_valid,
    input  logic                                   eoe_in,
    output logic [ADR_WIDTH-1:0]                   wr_row_addr,
    input  logic [ADR_WIDTH-1:0]                   rd_addr,
    output logic [WORDS_PER_ROW*WORD_WIDTH:0]      rd_data,
    input  logic                                   rel_valid,
    input  logic [ADR_WIDTH:0]                     rel_rows,
    output logic [ADR_WIDTH:0]                     rows_used,
    output logic                                   buf_full,
    output logic                                   buf_overflow,
    input  logic [HDR_WIDTH-1:0]                   hdr_data_in,
    input  logic                                   hdr_wrreq,
    input  logic                                   hdr_rdreq,
    output logic [HDR_WIDTH-1:0]                   hdr_data_out,
    output logic                                   hdr_full,
    output logic                                   hdr_empty,
    output logic                                   hdr_overflow,
    input  logic                                   clr_err,
    output logic [N_WVF_WIDTH-1:0]                 n_wvf_in_buf
);

    localparam int ROW_WIDTH = WORDS_PER_ROW*WORD_WIDTH+1;
    localparam int PH_W      = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam int BUF_DEPTH = 1 << ADR_WIDTH;
    localparam int HDR_DEPTH = 1 << HDR_DEPTH_LOG2;
    localparam logic [PH_W-1:0]          LAST_PHASE   = PH_W'(WORDS_PER_ROW-1);
    localparam logic [ADR_WIDTH:0]       BUF_ROWS     = {1'b1, {ADR_WIDTH{1'b0}}};
    localparam logic [HDR_DEPTH_LOG2:0]  HDR_FULL_CNT = {1'b1, {HDR_DEPTH_LOG2{1'b0}}};

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (!(WORDS_PER_ROW == 1 || WORDS_PER_ROW == 2 ||
              WORDS_PER_ROW == 4 || WORDS_PER_ROW == 8)) begin : g_bad_wpr
            $error("WORDS_PER_ROW must be 1, 2, 4 or 8");
        end
        if (WORD_WIDTH < 1 || ADR_WIDTH < 1 || HDR_WIDTH < 1) begin : g_bad_width
            $error("WORD_WIDTH, ADR_WIDTH and HDR_WIDTH must be positive");
        end
        if (HDR_DEPTH_LOG2 < 1) begin : g_bad_hdr_depth
            $error("HDR_DEPTH_LOG2 must be at least 1");
        end
        if (N_WVF_WIDTH < HDR_DEPTH_LOG2+1) begin : g_bad_nwvf
            $error("N_WVF_WIDTH must be >= HDR_DEPTH_LOG2+1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Packer
    // ------------------------------------------------------------------
    logic [WORD_WIDTH-1:0] r_lane [WORDS_PER_ROW];
    logic [PH_W-1:0]       r_phase;
    logic [ROW_WIDTH-1:0]  w_row;
    logic                  w_commit;
    logic                  w_accept;

    assign w_commit = word_valid && ((r_phase == LAST_PHASE) || eoe_in);
    assign w_accept = w_commit && !buf_full;

    // Lanes above the current phase are always zero because a commit clears them.
    always_comb begin
        w_row    = '0;
        w_row[0] = eoe_in;
        for (int i = 0; i < WORDS_PER_ROW; i++) begin
            w_row[i*WORD_WIDTH+1 +: WORD_WIDTH] =
                (PH_W'(i) == r_phase) ? word_in : r_lane[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
            for (int i = 0; i < WORDS_PER_ROW; i++) begin
                r_lane[i] <= '0;
            end
        end else if (word_valid) begin
            if (w_commit) begin
                r_phase <= '0;
                for (int i = 0; i < WORDS_PER_ROW; i++) begin
                    r_lane[i] <= '0;
                end
            end else begin
                r_phase <= r_phase + PH_W'(1);
                for (int i = 0; i < WORDS_PER_ROW; i++) begin
                    if (PH_W'(i) == r_phase) begin
                        r_lane[i] <= word_in;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Row RAM (read-first, registered read port)
    // ------------------------------------------------------------------
    logic [ROW_WIDTH-1:0] r_mem [BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[wr_row_addr] <= w_row;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= r_mem[rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // Write pointer, occupancy and overflow
    // ------------------------------------------------------------------
    logic [ADR_WIDTH+1:0] w_sum;
    logic [ADR_WIDTH+1:0] w_rel;
    logic [ADR_WIDTH+1:0] w_next_used;

    assign buf_full = (rows_used == BUF_ROWS);
    assign w_sum    = {1'b0, rows_used} + (ADR_WIDTH+2)'(w_accept);
    assign w_rel    = rel_valid ? {1'b0, rel_rows} : '0;
    // Over-release saturates at zero rather than wrapping.
    assign w_next_used = (w_rel > w_sum) ? '0 : (w_sum - w_rel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_row_addr  <= '0;
            rows_used    <= '0;
            buf_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                wr_row_addr <= wr_row_addr + ADR_WIDTH'(1);
            end
            rows_used <= w_next_used[ADR_WIDTH:0];
            if (w_commit && buf_full) begin
                buf_overflow <= 1'b1;
            end else if (clr_err) begin
                buf_overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Header FIFO (show-ahead)
    // ------------------------------------------------------------------
    logic [HDR_WIDTH-1:0]      r_hdr_mem [HDR_DEPTH];
    logic [HDR_DEPTH_LOG2-1:0] r_hdr_wr_ptr;
    logic [HDR_DEPTH_LOG2-1:0] r_hdr_rd_ptr;
    logic [HDR_DEPTH_LOG2:0]   r_hdr_count;
    logic                      w_push;
    logic                      w_pop;

    assign hdr_full     = (r_hdr_count == HDR_FULL_CNT);
    assign hdr_empty    = (r_hdr_count == '0);
    assign w_push       = hdr_wrreq && !hdr_full;
    assign w_pop        = hdr_rdreq && !hdr_empty;
    assign hdr_data_out = hdr_empty ? '0 : r_hdr_mem[r_hdr_rd_ptr];
    assign n_wvf_in_buf = N_WVF_WIDTH'(r_hdr_count);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_hdr_mem[r_hdr_wr_ptr] <= hdr_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr_wr_ptr <= '0;
            r_hdr_rd_ptr <= '0;
            r_hdr_count  <= '0;
            hdr_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_hdr_wr_ptr <= r_hdr_wr_ptr + HDR_DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_hdr_rd_ptr <= r_hdr_rd_ptr + HDR_DEPTH_LOG2'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_hdr_count <= r_hdr_count + (HDR_DEPTH_LOG2+1)'(1);
                2'b01:   r_hdr_count <= r_hdr_count - (HDR_DEPTH_LOG2+1)'(1);
                default: r_hdr_count <= r_hdr_count;
            endcase
            if (hdr_wrreq && hdr_full) begin
                hdr_overflow <= 1'b1;
            end else if (clr_err) begin
                hdr_overflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wvb_packed_storage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wvb_packed_storage
// Brief    : Directed self-checking bench for wvb_packed_storage.
// Revision : 1.0
// ============================================================================
module tb_wvb_packed_storage;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [20:0]  word_in;
    logic         word_valid, eoe_in;
    logic [9:0]   wr_row_addr, rd_addr;
    logic [84:0]  rd_data;
    logic         rel_valid;
    logic [10:0]  rel_rows, rows_used;
    logic         buf_full, buf_overflow;
    logic [103:0] hdr_data_in, hdr_data_out;
    logic         hdr_wrreq, hdr_rdreq, hdr_full, hdr_empty, hdr_overflow, clr_err;
    logic [15:0]  n_wvf_in_buf;

    logic [15:0]  word_in_1;
    logic         word_valid_1, eoe_in_1;
    logic [9:0]   wr_row_addr_1, rd_addr_1;
    logic [16:0]  rd_data_1;
    logic         rel_valid_1;
    logic [10:0]  rel_rows_1, rows_used_1;
    logic         buf_full_1, buf_overflow_1;
    logic [103:0] hdr_data_in_1, hdr_data_out_1;
    logic         hdr_wrreq_1, hdr_rdreq_1, hdr_full_1, hdr_empty_1, hdr_overflow_1, clr_err_1;
    logic [15:0]  n_wvf_in_buf_1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wvb_packed_storage u_dut (
        .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
        .eoe_in(eoe_in), .wr_row_addr(wr_row_addr), .rd_addr(rd_addr),
        .rd_data(rd_data), .rel_valid(rel_valid), .rel_rows(rel_rows),
        .rows_used(rows_used), .buf_full(buf_full), .buf_overflow(buf_overflow),
        .hdr_data_in(hdr_data_in), .hdr_wrreq(hdr_wrreq), .hdr_rdreq(hdr_rdreq),
        .hdr_data_out(hdr_data_out), .hdr_full(hdr_full), .hdr_empty(hdr_empty),
        .hdr_overflow(hdr_overflow), .clr_err(clr_err), .n_wvf_in_buf(n_wvf_in_buf)
    );

    wvb_packed_storage #(.WORD_WIDTH(16), .WORDS_PER_ROW(1)) u_dut_w1 (
        .clk(clk), .rst_n(rst_n), .word_in(word_in_1), .word_valid(word_valid_1),
        .eoe_in(eoe_in_1), .wr_row_addr(wr_row_addr_1), .rd_addr(rd_addr_1),
        .rd_data(rd_data_1), .rel_valid(rel_valid_1), .rel_rows(rel_rows_1),
        .rows_used(rows_used_1), .buf_full(buf_full_1), .buf_overflow(buf_overflow_1),
        .hdr_data_in(hdr_data_in_1), .hdr_wrreq(hdr_wrreq_1), .hdr_rdreq(hdr_rdreq_1),
        .hdr_data_out(hdr_data_out_1), .hdr_full(hdr_full_1), .hdr_empty(hdr_empty_1),
        .hdr_overflow(hdr_overflow_1), .clr_err(clr_err_1), .n_wvf_in_buf(n_wvf_in_buf_1)
    );

    function automatic logic [84:0] row4(input logic [20:0] l3, input logic [20:0] l2,
                                         input logic [20:0] l1, input logic [20:0] l0,
                                         input logic e);
        return {l3, l2, l1, l0, e};
    endfunction

    function automatic logic [103:0] hdr(input int i);
        return {8'h5A, 64'hDEAD_BEEF_0000_0000, 32'(i)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [20:0] w, input logic e);
        word_in = w; word_valid = 1'b1; eoe_in = e;
        tick();
        word_valid = 1'b0; eoe_in = 1'b0;
    endtask

    task automatic send1(input logic [15:0] w, input logic e);
        word_in_1 = w; word_valid_1 = 1'b1; eoe_in_1 = e;
        tick();
        word_valid_1 = 1'b0; eoe_in_1 = 1'b0;
    endtask

    task automatic read_row(input logic [9:0] a, input logic [84:0] exp, input string tag);
        rd_addr = a;
        tick();
        chk(tag, rd_data, exp);
    endtask

    task automatic push(input logic [103:0] d);
        hdr_data_in = d; hdr_wrreq = 1'b1;
        tick();
        hdr_wrreq = 1'b0;
    endtask

    task automatic release_rows(input logic [10:0] n);
        rel_valid = 1'b1; rel_rows = n;
        tick();
        rel_valid = 1'b0; rel_rows = '0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        word_in = '0; word_valid = 0; eoe_in = 0; rd_addr = '0;
        rel_valid = 0; rel_rows = '0; hdr_data_in = '0; hdr_wrreq = 0; hdr_rdreq = 0; clr_err = 0;
        word_in_1 = '0; word_valid_1 = 0; eoe_in_1 = 0; rd_addr_1 = '0;
        rel_valid_1 = 0; rel_rows_1 = '0; hdr_data_in_1 = '0; hdr_wrreq_1 = 0; hdr_rdreq_1 = 0;
        clr_err_1 = 0;
        #12;
        chk("rst_wr_row_addr", wr_row_addr, 10'd0);
        chk("rst_rows_used", rows_used, 11'd0);
        chk("rst_buf_full", buf_full, 1'b0);
        chk("rst_rd_data", rd_data, 85'd0);
        chk("rst_hdr_empty", hdr_empty, 1'b1);
        chk("rst_hdr_full", hdr_full, 1'b0);
        chk("rst_hdr_data_out", hdr_data_out, 104'd0);
        chk("rst_n_wvf", n_wvf_in_buf, 16'd0);
        chk("rst_flags", {buf_overflow, hdr_overflow}, 2'b00);
        rst_n = 1'b1;
        tick();

        // Single-word rows
        send1(16'h1111, 1'b0);
        send1(16'h2222, 1'b0);
        send1(16'h3333, 1'b1);
        chk("w1_wr_row_addr", wr_row_addr_1, 10'd3);
        chk("w1_rows_used", rows_used_1, 11'd3);
        rd_addr_1 = 10'd0; tick(); chk("w1_row0", rd_data_1, {16'h1111, 1'b0});
        rd_addr_1 = 10'd2; tick(); chk("w1_row2", rd_data_1, {16'h3333, 1'b1});

        // Eight words 1..8, eoe on the last
        for (int i = 1; i <= 8; i++) send(21'(i), (i == 8));
        chk("t1_wr_row_addr", wr_row_addr, 10'd2);
        chk("t1_rows_used", rows_used, 11'd2);
        read_row(10'd0, row4(21'd4, 21'd3, 21'd2, 21'd1, 1'b0), "t1_row0");
        read_row(10'd1, row4(21'd8, 21'd7, 21'd6, 21'd5, 1'b1), "t1_row1");

        // Short event, stray eoe, then a full row
        send(21'h0A, 1'b0); send(21'h0B, 1'b0); send(21'h0C, 1'b1);
        eoe_in = 1'b1; tick(); eoe_in = 1'b0;
        chk("t2_eoe_alone", wr_row_addr, 10'd3);
        send(21'h0D, 1'b0); send(21'h0E, 1'b0); send(21'h0F, 1'b0); send(21'h10, 1'b0);
        chk("t2_wr_row_addr", wr_row_addr, 10'd4);
        chk("t2_rows_used", rows_used, 11'd4);
        read_row(10'd2, row4(21'd0, 21'h0C, 21'h0B, 21'h0A, 1'b1), "t2_row2");
        read_row(10'd3, row4(21'h10, 21'h0F, 21'h0E, 21'h0D, 1'b0), "t2_row3");
        release_rows(11'd4);
        chk("t2_release", rows_used, 11'd0);

        // Header FIFO
        push(hdr(0));
        chk("f_n1", n_wvf_in_buf, 16'd1);
        chk("f_head0", hdr_data_out, hdr(0));
        for (int i = 1; i < 128; i++) push(hdr(i));
        chk("f_full", hdr_full, 1'b1);
        chk("f_n128", n_wvf_in_buf, 16'd128);
        chk("f_head_full", hdr_data_out, hdr(0));
        push(hdr(200));
        chk("f_ovf", hdr_overflow, 1'b1);
        chk("f_n_after_drop", n_wvf_in_buf, 16'd128);
        clr_err = 1'b1; push(hdr(201)); clr_err = 1'b0;
        chk("f_set_wins", hdr_overflow, 1'b1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("f_clr", hdr_overflow, 1'b0);
        hdr_rdreq = 1'b1; push(hdr(300)); hdr_rdreq = 1'b0;
        chk("f_poppush_full_n", n_wvf_in_buf, 16'd127);
        chk("f_poppush_full_head", hdr_data_out, hdr(1));
        chk("f_poppush_full_ovf", hdr_overflow, 1'b1);
        hdr_rdreq = 1'b1;
        for (int i = 0; i < 126; i++) tick();
        hdr_rdreq = 1'b0;
        chk("f_last_head", hdr_data_out, hdr(127));
        hdr_rdreq = 1'b1; tick(); tick(); hdr_rdreq = 1'b0;
        chk("f_empty", {hdr_empty, n_wvf_in_buf}, {1'b1, 16'd0});
        chk("f_empty_out", hdr_data_out, 104'd0);
        hdr_rdreq = 1'b1; push(hdr(400)); hdr_rdreq = 1'b0;
        chk("f_poppush_empty_n", n_wvf_in_buf, 16'd1);
        chk("f_poppush_empty_head", hdr_data_out, hdr(400));
        for (int i = 401; i <= 404; i++) push(hdr(i));
        chk("f_n5", n_wvf_in_buf, 16'd5);

        // Asynchronous reset mid-row and mid-FIFO
        send(21'h55, 1'b1);
        send(21'h11, 1'b0); send(21'h22, 1'b0);
        chk("r_pre_rows", rows_used, 11'd1);
        rst_n = 1'b0;
        #2;
        chk("r_async_n_wvf", n_wvf_in_buf, 16'd0);
        chk("r_async_empty", hdr_empty, 1'b1);
        chk("r_async_rows", rows_used, 11'd0);
        chk("r_async_wr", wr_row_addr, 10'd0);
        chk("r_async_rd_data", rd_data, 85'd0);
        rst_n = 1'b1;
        tick();
        send(21'h33, 1'b1);
        read_row(10'd0, row4(21'd0, 21'd0, 21'd0, 21'h33, 1'b1), "r_lane0");
        reset_pulse();

        // Fill the row buffer and overflow it
        for (int i = 0; i < 1024; i++) send(21'(i + 1), 1'b1);
        chk("o_rows_1024", rows_used, 11'd1024);
        chk("o_full", buf_full, 1'b1);
        chk("o_no_ovf_yet", buf_overflow, 1'b0);
        chk("o_wr_wrap", wr_row_addr, 10'd0);
        send(21'h1ABCD, 1'b0); send(21'h1BCDE, 1'b1);
        chk("o_ovf", buf_overflow, 1'b1);
        chk("o_wr_held", wr_row_addr, 10'd0);
        chk("o_rows_held", rows_used, 11'd1024);
        read_row(10'd0, row4(21'd0, 21'd0, 21'd0, 21'd1, 1'b1), "o_row0_kept");
        // Commit while full is dropped even when rows are released in the same cycle.
        rel_valid = 1'b1; rel_rows = 11'd4; send(21'h0F0F0, 1'b1); rel_valid = 1'b0;
        chk("o_rel_full_rows", rows_used, 11'd1020);
        chk("o_rel_full_wr", wr_row_addr, 10'd0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("o_clr", buf_overflow, 1'b0);
        rel_valid = 1'b1; rel_rows = 11'd4; send(21'h0F0F0, 1'b1); rel_valid = 1'b0;
        chk("o_rel_commit_rows", rows_used, 11'd1017);
        chk("o_rel_commit_wr", wr_row_addr, 10'd1);
        chk("o_not_full", buf_full, 1'b0);
        read_row(10'd0, row4(21'd0, 21'd0, 21'd0, 21'h0F0F0, 1'b1), "o_row0_new");
        rd_addr = 10'd1;
        send(21'h777, 1'b1);
        chk("o_read_first", rd_data, row4(21'd0, 21'd0, 21'd0, 21'd2, 1'b1));
        read_row(10'd1, row4(21'd0, 21'd0, 21'd0, 21'h777, 1'b1), "o_row1_new");
        release_rows(11'd2000);
        chk("o_clamp", rows_used, 11'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
